// File: rtl/wb_hazard_ctrl.sv
// Write-back issue/retire controller: per-register RAW scoreboard, in-flight limit, registered WB strobes.
// Optional macro WB_HAZARD_BYPASS_EN lets a same-cycle retire release a source hazard or a full stall.
module wb_hazard_ctrl #(
    parameter int REG_AW = 3,
    parameter int MAX_INFLIGHT = 3,
    localparam int CW = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [3:0]        id_op_code,
    input  logic [REG_AW-1:0] id_sr_addr,
    input  logic [REG_AW-1:0] id_tr_addr,
    input  logic [REG_AW-1:0] id_dr_addr,
    input  logic              wb_valid,
    input  logic [3:0]        wb_op_code,
    input  logic [REG_AW-1:0] wb_dr_addr,
    output logic              stall,
    output logic              issue,
    output logic              reg_we,
    output logic              ram_we,
    output logic              dr_sel_ram,
    output logic [CW-1:0]     inflight,
    output logic              sb_err
);
    localparam int NREG = 1 << REG_AW;
    localparam logic [3:0] OP_NOP0  = 4'b0100;
    localparam logic [3:0] OP_NOP1  = 4'b0101;
    localparam logic [3:0] OP_LOAD  = 4'b0110;
    localparam logic [3:0] OP_STORE = 4'b0111;

    logic [CW-1:0] r_cnt [NREG];
    logic [CW-1:0] r_inflight;
    logic          r_reg_we;
    logic          r_ram_we;
    logic          r_dr_sel_ram;
    logic          r_sb_err;

    function automatic logic f_writes(input logic [3:0] op);
        return !(op == OP_STORE || op == OP_NOP0 || op == OP_NOP1);
    endfunction

    logic            w_id_writes;
    logic            w_wb_writes;
    logic [CW-1:0]   w_cnt_s;
    logic [CW-1:0]   w_cnt_t;
    logic [CW-1:0]   w_cnt_wb;
    logic            w_haz_s;
    logic            w_haz_t;
    logic            w_full;
    logic            w_stall;
    logic            w_issue;
    logic            w_underflow;
    logic [NREG-1:0] w_inc;
    logic [NREG-1:0] w_dec;

    assign w_cnt_s     = r_cnt[id_sr_addr];
    assign w_cnt_t     = r_cnt[id_tr_addr];
    assign w_cnt_wb    = r_cnt[wb_dr_addr];
    assign w_wb_writes = wb_valid && f_writes(wb_op_code);

`ifdef WB_HAZARD_BYPASS_EN
    // A retiring writer that is the last pending one for a source frees it this cycle.
    logic w_byp_s;
    logic w_byp_t;
    assign w_byp_s = w_wb_writes && (wb_dr_addr == id_sr_addr) && (w_cnt_s == CW'(1));
    assign w_byp_t = w_wb_writes && (wb_dr_addr == id_tr_addr) && (w_cnt_t == CW'(1));
    assign w_haz_s = (w_cnt_s != '0) && !w_byp_s;
    assign w_haz_t = (w_cnt_t != '0) && !w_byp_t;
    assign w_full  = (r_inflight == CW'(MAX_INFLIGHT)) && !wb_valid;
`else
    assign w_haz_s = (w_cnt_s != '0);
    assign w_haz_t = (w_cnt_t != '0);
    assign w_full  = (r_inflight == CW'(MAX_INFLIGHT));
`endif

    assign w_stall     = id_valid && (w_haz_s || w_haz_t || w_full);
    assign w_issue     = id_valid && !w_stall;
    assign w_id_writes = w_issue && f_writes(id_op_code);
    assign w_underflow = (w_wb_writes && (w_cnt_wb == '0)) || (wb_valid && (r_inflight == '0));

    always_comb begin
        w_inc = '0;
        w_dec = '0;
        for (int i = 0; i < NREG; i++) begin
            w_inc[i] = w_id_writes && (id_dr_addr == REG_AW'(i));
            w_dec[i] = w_wb_writes && (wb_dr_addr == REG_AW'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_cnt[i] <= '0;
            end
            r_inflight   <= '0;
            r_reg_we     <= 1'b0;
            r_ram_we     <= 1'b0;
            r_dr_sel_ram <= 1'b0;
            r_sb_err     <= 1'b0;
        end else begin
            // Simultaneous issue and retire on one register cancel out.
            for (int i = 0; i < NREG; i++) begin
                if (w_inc[i] && !w_dec[i]) begin
                    r_cnt[i] <= r_cnt[i] + CW'(1);
                end else if (w_dec[i] && !w_inc[i] && (r_cnt[i] != '0)) begin
                    r_cnt[i] <= r_cnt[i] - CW'(1);
                end
            end
            if (w_issue && !wb_valid) begin
                r_inflight <= r_inflight + CW'(1);
            end else if (wb_valid && !w_issue && (r_inflight != '0)) begin
                r_inflight <= r_inflight - CW'(1);
            end
            if (w_underflow) begin
                r_sb_err <= 1'b1;
            end
            r_reg_we     <= w_wb_writes;
            r_ram_we     <= wb_valid && (wb_op_code == OP_STORE);
            r_dr_sel_ram <= wb_valid && (wb_op_code == OP_LOAD);
        end
    end

    assign stall      = w_stall;
    assign issue      = w_issue;
    assign reg_we     = r_reg_we;
    assign ram_we     = r_ram_we;
    assign dr_sel_ram = r_dr_sel_ram;
    assign inflight   = r_inflight;
    assign sb_err     = r_sb_err;
endmodule

// File: tb/tb_wb_hazard_ctrl.sv
// Bench for wb_hazard_ctrl: directed plan steps plus random in-order issue/retire traffic,
// checked against a model that tracks pending writes as a list of destination registers.
module tb_wb_hazard_ctrl;
    localparam int REG_AW = 3;
    localparam int MAX_INFLIGHT = 3;
    localparam int CW = $clog2(MAX_INFLIGHT + 1);

    logic              clk = 1'b0;
    logic              rst;
    logic              id_valid;
    logic [3:0]        id_op_code;
    logic [REG_AW-1:0] id_sr_addr;
    logic [REG_AW-1:0] id_tr_addr;
    logic [REG_AW-1:0] id_dr_addr;
    logic              wb_valid;
    logic [3:0]        wb_op_code;
    logic [REG_AW-1:0] wb_dr_addr;
    logic              stall;
    logic              issue;
    logic              reg_we;
    logic              ram_we;
    logic              dr_sel_ram;
    logic [CW-1:0]     inflight;
    logic              sb_err;

    wb_hazard_ctrl #(.REG_AW(REG_AW), .MAX_INFLIGHT(MAX_INFLIGHT)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_op_code(id_op_code),
        .id_sr_addr(id_sr_addr), .id_tr_addr(id_tr_addr), .id_dr_addr(id_dr_addr),
        .wb_valid(wb_valid), .wb_op_code(wb_op_code), .wb_dr_addr(wb_dr_addr),
        .stall(stall), .issue(issue), .reg_we(reg_we), .ram_we(ram_we),
        .dr_sel_ram(dr_sel_ram), .inflight(inflight), .sb_err(sb_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: destinations of pending register writes, issued count, and expected strobes.
    typedef struct {
        logic [3:0]        op;
        logic [REG_AW-1:0] dr;
    } inst_t;

    int    pend[$];
    int    m_flight;
    bit    m_err;
    bit    m_reg_we;
    bit    m_ram_we;
    bit    m_sel;
    inst_t iq[$];

    function automatic bit writes(input logic [3:0] op);
        return !(op inside {4'b0100, 4'b0101, 4'b0111});
    endfunction

    function automatic int count_pend(input int r);
        int c = 0;
        foreach (pend[k]) if (pend[k] == r) c++;
        return c;
    endfunction

    task automatic model_reset();
        pend.delete();
        iq.delete();
        m_flight = 0;
        m_err    = 0;
        m_reg_we = 0;
        m_ram_we = 0;
        m_sel    = 0;
    endtask

    task automatic run_cycle(input bit r, input bit iv, input logic [3:0] iop,
                             input logic [REG_AW-1:0] s, input logic [REG_AW-1:0] t,
                             input logic [REG_AW-1:0] d, input bit wv,
                             input logic [3:0] wop, input logic [REG_AW-1:0] wd);
        int  cs, ct, idx;
        bit  haz_s, haz_t, full, e_stall, e_issue;
        inst_t ent;
        @(negedge clk);
        rst = r; id_valid = iv; id_op_code = iop;
        id_sr_addr = s; id_tr_addr = t; id_dr_addr = d;
        wb_valid = wv; wb_op_code = wop; wb_dr_addr = wd;
        #1;
        cs = count_pend(int'(s));
        ct = count_pend(int'(t));
        haz_s = (cs > 0);
        haz_t = (ct > 0);
        full  = (m_flight == MAX_INFLIGHT);
`ifdef WB_HAZARD_BYPASS_EN
        if (wv && writes(wop) && wd == s && cs == 1) haz_s = 0;
        if (wv && writes(wop) && wd == t && ct == 1) haz_t = 0;
        if (wv) full = 0;
`endif
        e_stall = iv && (haz_s || haz_t || full);
        e_issue = iv && !e_stall;
        check("stall", stall, e_stall);
        check("issue", issue, e_issue);
        @(posedge clk);
        if (r) begin
            model_reset();
        end else begin
            if (wv) begin
                if (m_flight == 0) m_err = 1;
                else m_flight--;
                if (writes(wop)) begin
                    idx = -1;
                    foreach (pend[k]) if (idx < 0 && pend[k] == int'(wd)) idx = k;
                    if (idx < 0) m_err = 1;
                    else pend.delete(idx);
                end
                if (iq.size() > 0) void'(iq.pop_front());
            end
            if (e_issue) begin
                m_flight++;
                if (writes(iop)) pend.push_back(int'(d));
                ent.op = iop;
                ent.dr = d;
                iq.push_back(ent);
            end
            m_reg_we = wv && writes(wop);
            m_ram_we = wv && (wop == 4'b0111);
            m_sel    = wv && (wop == 4'b0110);
        end
        #1;
        check("reg_we", reg_we, m_reg_we);
        check("ram_we", ram_we, m_ram_we);
        check("dr_sel_ram", dr_sel_ram, m_sel);
        check("inflight", inflight, m_flight);
        check("sb_err", sb_err, m_err);
    endtask

    task automatic idle_cycle();
        run_cycle(0, 0, 4'b0000, 0, 0, 0, 0, 4'b0000, 0);
    endtask

    task automatic drain();
        int guard = 0;
        while (iq.size() > 0 && guard < 16) begin
            run_cycle(0, 0, 4'b0000, 0, 0, 0, 1, iq[0].op, iq[0].dr);
            guard++;
        end
        check("drain_done", iq.size(), 0);
    endtask

    bit               rr, rv, rw;
    logic [3:0]       rop, rwop;
    logic [REG_AW-1:0] rs, rt, rd, rwd;

    initial begin
        rst = 1; id_valid = 0; id_op_code = 0; id_sr_addr = 0; id_tr_addr = 0;
        id_dr_addr = 0; wb_valid = 0; wb_op_code = 0; wb_dr_addr = 0;
        model_reset();
        run_cycle(1, 0, 4'b0000, 0, 0, 0, 0, 4'b0000, 0);
        run_cycle(1, 0, 4'b0000, 0, 0, 0, 0, 4'b0000, 0);
        check("reset_inflight", inflight, 0);
        check("reset_sb_err", sb_err, 0);

        // First issue: no hazards after reset.
        run_cycle(0, 1, 4'b0001, 1, 2, 3, 0, 4'b0000, 0);
        check("plan_inflight_1", inflight, 1);
        // RAW on r3, then retire of r3 in the same cycle as the stalled request.
        run_cycle(0, 1, 4'b0001, 3, 0, 0, 0, 4'b0000, 0);
        run_cycle(0, 1, 4'b0001, 3, 0, 0, 1, 4'b0001, 3);
        check("plan_reg_we", reg_we, 1);
        run_cycle(0, 1, 4'b0001, 3, 0, 0, 0, 4'b0000, 0);
        drain();

        // Fill the pipeline, then contend a retire with a full stall.
        run_cycle(0, 1, 4'b0001, 0, 0, 1, 0, 4'b0000, 0);
        run_cycle(0, 1, 4'b0110, 0, 0, 2, 0, 4'b0000, 0);
        run_cycle(0, 1, 4'b0111, 0, 0, 4, 0, 4'b0000, 0);
        check("plan_full", inflight, 3);
        run_cycle(0, 1, 4'b0001, 5, 6, 5, 0, 4'b0000, 0);
        run_cycle(0, 1, 4'b0001, 5, 6, 5, 1, iq[0].op, iq[0].dr);
        run_cycle(0, 0, 4'b0000, 0, 0, 0, 1, iq[0].op, iq[0].dr);
        check("plan_load_sel", dr_sel_ram, 1);
        check("plan_load_ram_we", ram_we, 0);
        run_cycle(0, 0, 4'b0000, 0, 0, 0, 1, iq[0].op, iq[0].dr);
        check("plan_store_ram_we", ram_we, 1);
        check("plan_store_reg_we", reg_we, 0);
        drain();
        run_cycle(0, 1, 4'b0101, 0, 0, 6, 0, 4'b0000, 0);
        run_cycle(0, 0, 4'b0000, 0, 0, 0, 1, 4'b0101, 6);
        check("plan_nop_reg_we", reg_we, 0);

        // Same-register issue and retire in one cycle keeps the count.
        run_cycle(0, 1, 4'b0001, 0, 0, 2, 0, 4'b0000, 0);
        run_cycle(0, 1, 4'b0001, 0, 0, 2, 1, 4'b0001, 2);
        run_cycle(0, 1, 4'b0001, 2, 2, 0, 0, 4'b0000, 0);
        drain();

        // Retire with nothing pending on r7: sticky error, then reset clears it.
        run_cycle(0, 0, 4'b0000, 0, 0, 0, 1, 4'b0001, 7);
        check("plan_sb_err", sb_err, 1);
        idle_cycle();
        idle_cycle();
        run_cycle(1, 1, 4'b0001, 0, 0, 1, 1, 4'b0110, 1);
        check("plan_rst_err", sb_err, 0);
        run_cycle(0, 1, 4'b0001, 7, 7, 7, 0, 4'b0000, 0);

        for (int n = 0; n < 1500; n++) begin
            rr  = ($urandom_range(0, 99) == 0);
            rv  = ($urandom_range(0, 3) != 0);
            rop = 4'($urandom_range(0, 15));
            rs  = REG_AW'($urandom_range(0, 7));
            rt  = REG_AW'($urandom_range(0, 7));
            rd  = REG_AW'($urandom_range(0, 7));
            rw  = (iq.size() > 0) && ($urandom_range(0, 2) != 0);
            rwop = 4'($urandom_range(0, 15));
            rwd  = REG_AW'($urandom_range(0, 7));
            if (rw) begin
                rwop = iq[0].op;
                rwd  = iq[0].dr;
            end
            run_cycle(rr, rv, rop, rs, rt, rd, rw, rwop, rwd);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
